// File: rtl/traffic_pkg.sv
// traffic_pkg: state codes, lamp patterns and default timings for the junction sequencer
package traffic_pkg;
  typedef enum logic [2:0] {
    ALL_RED1  = 3'd0,
    A_GRN     = 3'd1,
    A_YEL     = 3'd2,
    ALL_RED2  = 3'd3,
    B_GRN     = 3'd4,
    B_YEL     = 3'd5,
    FLASH_ON  = 3'd6,
    FLASH_OFF = 3'd7
  } state_e;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;
  localparam int T_GREEN_A_DEF = 20;
  localparam int T_GREEN_B_DEF = 20;
  localparam int T_YELLOW_DEF  = 4;
  localparam int T_ALLRED_DEF  = 2;
  localparam int T_FLASH_DEF   = 4;
  localparam int CNT_W_DEF     = 8;
  function automatic logic is_flash(state_e s);
    return s == FLASH_ON || s == FLASH_OFF;
  endfunction
endpackage

// File: rtl/traffic_junction_ctrl_phase_timer.sv
// phase_timer: counts tick pulses within one phase, flags the final tick, optionally saturates there
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             clear,
  input  logic             hold,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             done
);
  logic [CNT_W-1:0] count_q, count_d;
  logic at_end;
  assign at_end = count_q == limit - 1'b1;
  assign done   = tick && at_end;
  assign count  = count_q;
  // Next count: clear wins, otherwise advance per tick unless parked at the last value in hold mode.
  always_comb count_d = clear ? '0 : (tick && !(hold && at_end)) ? count_q + 1'b1 : count_q;
  // Counter register.
  always_ff @(posedge clock) count_q <= reset ? '0 : count_d;
endmodule

// File: rtl/traffic_junction_ctrl.sv
// traffic_junction_ctrl: tick-timed main/side road sequencer with latched side request and night flash
module traffic_junction_ctrl
  import traffic_pkg::*;
#(
  parameter int T_GREEN_A = T_GREEN_A_DEF,
  parameter int T_GREEN_B = T_GREEN_B_DEF,
  parameter int T_YELLOW  = T_YELLOW_DEF,
  parameter int T_ALLRED  = T_ALLRED_DEF,
  parameter int T_FLASH   = T_FLASH_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       X,
  input  logic       req_b,
  output logic       a_red,
  output logic       a_yel,
  output logic       a_grn,
  output logic       b_red,
  output logic       b_yel,
  output logic       b_grn,
  output logic [2:0] state_o,
  output logic       req_pend
);
  localparam logic [CNT_W-1:0] L_GA = CNT_W'(T_GREEN_A);
  localparam logic [CNT_W-1:0] L_GB = CNT_W'(T_GREEN_B);
  localparam logic [CNT_W-1:0] L_Y  = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] L_AR = CNT_W'(T_ALLRED);
  localparam logic [CNT_W-1:0] L_F  = CNT_W'(T_FLASH);
  state_e state_q, state_d;
  logic req_pend_q, req_pend_d;
  logic [CNT_W-1:0] limit, count;
  logic done;
  logic [2:0] a_l, b_l;
  assign limit = (state_q == A_GRN) ? L_GA :
                 (state_q == B_GRN) ? L_GB :
                 (state_q == A_YEL || state_q == B_YEL) ? L_Y :
                 is_flash(state_q) ? L_F : L_AR;
  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
    .clear (state_d != state_q),
    .hold  (state_q == A_GRN),
    .limit (limit),
    .count (count),
    .done  (done)
  );
  // Next state: only a tick can move the sequence; yellow always runs its full length.
  always_comb begin
    state_d = state_q;
    if (tick)
      case (state_q)
        ALL_RED1: state_d = !X ? FLASH_ON : done ? A_GRN : state_q;
        A_GRN:    state_d = (!X || (done && req_pend_q)) ? A_YEL : state_q;
        A_YEL:    state_d = !done ? state_q : X ? ALL_RED2 : FLASH_ON;
        ALL_RED2: state_d = !X ? FLASH_ON : done ? B_GRN : state_q;
        B_GRN:    state_d = (!X || done) ? B_YEL : state_q;
        B_YEL:    state_d = !done ? state_q : X ? ALL_RED1 : FLASH_ON;
        FLASH_ON: state_d = X ? ALL_RED1 : done ? FLASH_OFF : state_q;
        default:  state_d = X ? ALL_RED1 : done ? FLASH_ON : state_q;
      endcase
  end
  // Side request latch: flushed around night mode, a new request beats the clear on B green entry.
  always_comb req_pend_d = (is_flash(state_q) || is_flash(state_d)) ? 1'b0 :
                           req_b ? 1'b1 :
                           (state_d == B_GRN && state_q != B_GRN) ? 1'b0 : req_pend_q;
  // State and request registers.
  always_ff @(posedge clock) begin
    state_q    <= reset ? ALL_RED1 : state_d;
    req_pend_q <= reset ? 1'b0 : req_pend_d;
  end
  // The phase counter must stay below the active phase length.
  always_ff @(posedge clock) if (!reset) assert (count < limit);
  // Lamp decode straight from the registered state.
  always_comb begin
    a_l = (state_q == A_GRN) ? GRN :
          (state_q == A_YEL || state_q == FLASH_ON) ? YEL :
          (state_q == FLASH_OFF) ? OFF : RED;
    b_l = (state_q == B_GRN) ? GRN :
          (state_q == B_YEL || state_q == FLASH_ON) ? YEL :
          (state_q == FLASH_OFF) ? OFF : RED;
  end
  assign {a_red, a_yel, a_grn} = a_l;
  assign {b_red, b_yel, b_grn} = b_l;
  assign state_o  = state_q;
  assign req_pend = req_pend_q;
endmodule

// File: tb/tb_traffic_junction_ctrl.sv
// tb_traffic_junction_ctrl: scoreboard bench with directed phase vectors and a random invariant soak
module tb_traffic_junction_ctrl;
  bit clk = 0;
  logic rst = 1, tick = 0, x = 1, req_b = 0;
  logic a_red, a_yel, a_grn, b_red, b_yel, b_grn, req_pend;
  logic [2:0] state_o;
  logic [9:0] q[$];
  bit strobe = 0, rst_d = 0, sb_on = 1, fin = 0;
  logic [2:0] prev_s = 3'd0;
  int checks = 0, errs = 0, vec = 0;

  always #5 clk = ~clk;

  traffic_junction_ctrl dut (
    .clock   (clk),
    .reset   (rst),
    .tick    (tick),
    .X       (x),
    .req_b   (req_b),
    .a_red   (a_red),
    .a_yel   (a_yel),
    .a_grn   (a_grn),
    .b_red   (b_red),
    .b_yel   (b_yel),
    .b_grn   (b_grn),
    .state_o (state_o),
    .req_pend(req_pend)
  );

  function automatic logic [5:0] lamps(input logic [2:0] s);
    case (s)
      3'd1: return 6'b001_100;
      3'd2: return 6'b010_100;
      3'd4: return 6'b100_001;
      3'd5: return 6'b100_010;
      3'd6: return 6'b010_010;
      3'd7: return 6'b000_000;
      default: return 6'b100_100;
    endcase
  endfunction

  task automatic rst_cyc(input int n);
    rst = 1;
    repeat (n) begin
      q.push_back({3'd0, lamps(3'd0), 1'b0});
      @(negedge clk);
    end
    rst = 0;
  endtask

  task automatic tk(input bit xv, input bit r, input logic [2:0] s, input bit p);
    x = xv;
    req_b = r;
    tick = 1;
    q.push_back({s, lamps(s), p});
    @(negedge clk);
    tick = 0;
    req_b = 0;
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit xv, input logic [2:0] s, input bit p);
    repeat (n) tk(xv, 1'b0, s, p);
  endtask

  task automatic req();
    req_b = 1;
    @(negedge clk);
    req_b = 0;
  endtask

  always @(posedge clk) begin
    strobe <= tick | rst;
    rst_d  <= rst;
  end

  always @(negedge clk) begin
    logic [9:0] e, a;
    logic bad;
    if (strobe && sb_on) begin
      checks++;
      vec++;
      a = {state_o, a_red, a_yel, a_grn, b_red, b_yel, b_grn, req_pend};
      if (q.size() == 0) begin
        errs++;
        $display("FAIL scoreboard_underflow vec %0d got %b", vec, a);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          errs++;
          $display("FAIL scoreboard vec %0d got state %0d lamps %b pend %b, want state %0d lamps %b pend %b",
                   vec, a[9:7], a[6:1], a[0], e[9:7], e[6:1], e[0]);
        end
      end
    end
    checks++;
    bad = (a_grn && b_grn) ||
          (state_o < 3'd6 && ((a_grn && !(b_red && !b_yel && !b_grn)) ||
                              (b_grn && !(a_red && !a_yel && !a_grn))));
    if (!rst_d)
      bad = bad || (prev_s == 3'd1 && state_o != 3'd1 && state_o != 3'd2) ||
                   (prev_s == 3'd4 && state_o != 3'd4 && state_o != 3'd5) ||
                   (state_o == 3'd1 && prev_s != 3'd1 && prev_s != 3'd0) ||
                   (state_o == 3'd4 && prev_s != 3'd4 && prev_s != 3'd3);
    if (bad) begin
      errs++;
      $display("FAIL invariant prev %0d state %0d lamps %b%b%b_%b%b%b", prev_s, state_o,
               a_red, a_yel, a_grn, b_red, b_yel, b_grn);
    end
    prev_s <= state_o;
    if (fin) begin
      checks++;
      if (q.size() != 0) begin
        errs++;
        $display("FAIL scoreboard_drain got %0d left want 0", q.size());
      end
    end
  end

  initial begin
    // reset, then ALL_RED1 for 2 ticks and A_GRN held with no demand
    rst_cyc(3);
    run(1, 1, 3'd0, 0); tk(1, 0, 3'd1, 0);
    run(100, 1, 3'd1, 0);
    // late request: leaves on the very next tick
    req(); tk(1, 0, 3'd2, 1); run(3, 1, 3'd2, 1);
    tk(1, 0, 3'd3, 1); run(1, 1, 3'd3, 1);
    tk(1, 0, 3'd4, 0); run(19, 1, 3'd4, 0);
    tk(1, 0, 3'd5, 0); run(3, 1, 3'd5, 0);
    tk(1, 0, 3'd0, 0); run(1, 1, 3'd0, 0);
    tk(1, 0, 3'd1, 0);
    // side-road cycle with request after 4 ticks of green
    run(4, 1, 3'd1, 0); req(); run(15, 1, 3'd1, 1);
    tk(1, 0, 3'd2, 1); run(3, 1, 3'd2, 1);
    tk(1, 0, 3'd3, 1); run(1, 1, 3'd3, 1);
    tk(1, 0, 3'd4, 0); run(19, 1, 3'd4, 0);
    tk(1, 0, 3'd5, 0); run(3, 1, 3'd5, 0);
    tk(1, 0, 3'd0, 0); run(1, 1, 3'd0, 0);
    tk(1, 0, 3'd1, 0);
    // set beats clear on B entry, then night mode mid B_GRN
    req(); run(19, 1, 3'd1, 1);
    tk(1, 0, 3'd2, 1); run(3, 1, 3'd2, 1);
    tk(1, 0, 3'd3, 1); run(1, 1, 3'd3, 1);
    tk(1, 1, 3'd4, 1); run(5, 1, 3'd4, 1);
    tk(0, 0, 3'd5, 1); run(3, 0, 3'd5, 1);
    tk(0, 0, 3'd6, 0); req(); run(3, 0, 3'd6, 0);
    tk(0, 0, 3'd7, 0); run(3, 0, 3'd7, 0);
    tk(0, 0, 3'd6, 0); run(3, 0, 3'd6, 0);
    tk(0, 0, 3'd7, 0); run(1, 0, 3'd7, 0);
    // night exit from FLASH_OFF
    tk(1, 0, 3'd0, 0); run(1, 1, 3'd0, 0);
    tk(1, 0, 3'd1, 0);
    // night request during A_GRN: yellow runs full, pending flushed on flash entry
    req(); tk(0, 0, 3'd2, 1); run(3, 0, 3'd2, 1);
    tk(0, 0, 3'd6, 0);
    tk(1, 0, 3'd0, 0); run(1, 1, 3'd0, 0);
    tk(1, 0, 3'd1, 0);
    // reset mid A_YEL restarts the all-red count from zero
    req(); run(19, 1, 3'd1, 1);
    tk(1, 0, 3'd2, 1); run(1, 1, 3'd2, 1);
    rst_cyc(1);
    run(1, 1, 3'd0, 0); tk(1, 0, 3'd1, 0);
    run(5, 1, 3'd1, 0);
    // random soak, invariants only
    @(negedge clk);
    sb_on = 0;
    repeat (10000) begin
      tick  = 1'($urandom % 2);
      x     = ($urandom % 8) != 0;
      req_b = ($urandom % 16) == 0;
      @(negedge clk);
    end
    tick = 0;
    req_b = 0;
    x = 1;
    fin = 1;
    @(negedge clk);
    #1 fin = 0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule

// File: doc/traffic_junction_ctrl.md
Name: traffic_junction_ctrl

Overview:
- Synchronous sequencer for a two-approach junction: approach A is the main road and approach B is the side road. Each approach has one red/yellow/green lamp set.
- Replaces delay-based sequencing with a tick-counted FSM.
- Arbitrates the green phase between A and B from a latched side-road request.
- Supports a night mode that flashes yellow on both approaches.
- Sits between the 1 Hz tick generator and the lamp drivers.

Parameters:
- T_GREEN_A, 20, minimum A green, in ticks (>=1)
- T_GREEN_B, 20, fixed B green, in ticks (>=1)
- T_YELLOW, 4, yellow duration for either approach, in ticks (>=1)
- T_ALLRED, 2, all-red clearance, in ticks (>=1)
- T_FLASH, 4, flash on/off half-period, in ticks (>=1)
- CNT_W, 8, tick counter width; every T_* must be < 2**CNT_W

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- tick  in  1  one-clock enable pulse, nominally 1 Hz; all timing counts only these pulses
- X  in  1  mode: 1 = normal cycling, 0 = night flashing; sampled on tick
- req_b  in  1  side-road demand (sensor/pushbutton), level or pulse
- a_red, a_yel, a_grn  out  1 each  approach A lamps
- b_red, b_yel, b_grn  out  1 each  approach B lamps
- state_o  out  3  current FSM state code, for debug/status
- req_pend  out  1  latched B request pending

Behaviour:
- Reset (on the clock edge with reset=1):
  - state = ALL_RED1, counter = 0, req_pend = 0
  - lamps: a_red = b_red = 1, all others 0
  - reset overrides tick, X and req_b in the same cycle, and mid-phase reset aborts immediately.
- Lamps are a combinational decode of the registered state. They change in the same cycle as state_o, with no extra latency.
- States, codes and lamp decode:
  - ALL_RED1=0: both red
  - A_GRN=1: A green, B red
  - A_YEL=2: A yellow, B red
  - ALL_RED2=3: both red
  - B_GRN=4: B green, A red
  - B_YEL=5: B yellow, A red
  - FLASH_ON=6: a_yel = b_yel = 1, others 0
  - FLASH_OFF=7: all six lamps 0
- Counter:
  - increments only on tick; it is cleared on every state change.
  - "phase done" means tick=1 and counter == T_phase-1.
  - The transition happens on that clock edge, so each phase lasts exactly T_phase ticks.
- Transitions (evaluated only when tick=1):
  - ALL_RED1: X=0 -> FLASH_ON immediately. Otherwise, on done(T_ALLRED) -> A_GRN.
  - A_GRN: X=0 -> A_YEL immediately. Otherwise, on done(T_GREEN_A) with req_pend=1 -> A_YEL.
    - If done but req_pend=0, stay in A_GRN and hold the counter at T_GREEN_A-1 (no wrap).
    - A_GRN then leaves on the first tick with req_pend=1.
  - A_YEL: done(T_YELLOW) -> FLASH_ON if X=0, else ALL_RED2. Yellow is never truncated.
  - ALL_RED2: X=0 -> FLASH_ON. Otherwise, on done(T_ALLRED) -> B_GRN.
  - B_GRN: X=0 -> B_YEL immediately. Otherwise, on done(T_GREEN_B) -> B_YEL.
  - B_YEL: done(T_YELLOW) -> FLASH_ON if X=0, else ALL_RED1.
  - FLASH_ON and FLASH_OFF: X=1 -> ALL_RED1 (counter cleared). Otherwise, on done(T_FLASH) toggle to the other flash state.
- Request latch:
  - req_pend is set on any clock with req_b=1 (tick not required).
  - It is cleared on entry to B_GRN.
  - Set and clear in the same cycle: the set wins, so the request is queued for the next cycle.
  - req_pend is cleared on entry to FLASH_ON from a non-flash state.
  - It is ignored (held 0) while in FLASH_ON or FLASH_OFF.
- Safety invariants:
  - Never any green on both approaches.
  - Never green on one approach while the other is not red, except in the flash states.
  - Green is always followed by yellow.
  - Every return to green passes through an all-red state.
- tick high on consecutive clocks is legal; each pulse counts once.

Decomposition:
- Package traffic_pkg:
  - 3-bit state encodings (values above)
  - lamp-vector constants RED/YEL/GRN/OFF as {red, yel, grn}
  - default timing constants
- Sub-module phase_timer (CNT_W):
  - inputs: clock, reset, tick, clear, hold, limit
  - outputs: count, done
- The FSM and lamp decode stay in traffic_junction_ctrl.

Test Plan:
- Reset behaviour: reset held 3 clocks, then released with X=1, req_b=0 -> both red, state_o=0. After 2 ticks, A_GRN. A_GRN is then held indefinitely (tested for 100 ticks) with no B green.
- Side-road cycle: X=1, req_b pulse at tick 5 of A_GRN -> A_GRN ends at tick 20, A_YEL for 4 ticks, ALL_RED2 for 2, B_GRN for 20, B_YEL for 4, ALL_RED1. req_pend=0 from B_GRN entry.
- Late request: req_b asserted after A_GRN has passed tick 20 -> A_YEL begins on the next tick, not later.
- Night-mode entry: X->0 mid B_GRN -> B_YEL immediately, full 4 ticks, then FLASH_ON/FLASH_OFF alternating every 4 ticks (both yellow, then all off).
- Night-mode exit: X->1 during FLASH_OFF -> ALL_RED1 on the next tick, then A_GRN after 2 ticks.
- Reset and invariants: reset asserted mid A_YEL -> next clock both red, counter 0. A random tick/X/req_b soak (10k clocks) with the safety-invariant checker attached reports 0 violations.
